// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator: extracts and extends the instruction immediate,
// buffers results in a 2-entry skid buffer with tag pass-through and illegal-select counting.
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  state_e           state_q, state_d;
  entry_t           main_q, main_d, skid_q, skid_d, new_s;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [32:0]      ext_s;
  logic             in_fire_s, out_fire_s;

  // Returns {illegal, imm32}; the 32-bit value is sign-extended to XLEN afterwards.
  function automatic logic [32:0] extract(input logic [31:0] instr, input logic [2:0] sel);
    logic [32:0] r;
    case (sel)
      3'b000:  r = {1'b0, {20{instr[31]}}, instr[31:20]};
      3'b001:  r = {1'b0, {20{instr[31]}}, instr[31:25], instr[11:7]};
      3'b010:  r = {1'b0, {19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      3'b011:  r = {1'b0, instr[31:12], 12'h000};
      3'b100:  r = {1'b0, {11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      3'b101:  r = {1'b0, 27'd0, instr[19:15]};
      default: r = {1'b1, 32'd0};
    endcase
    return r;
  endfunction

  // Input-side extraction and handshake qualification.
  always_comb begin
    ext_s      = extract(in_instr, in_imm_sel);
    new_s.imm  = XLEN'($signed(ext_s[31:0]));
    new_s.tag  = in_tag;
    new_s.err  = ext_s[32];
    in_ready   = (state_q != ST_FULL) & ~rst;
    in_fire_s  = in_valid & in_ready & ~flush;
    out_fire_s = out_valid & out_ready;
  end

  // Skid-buffer next state and saturating error counter.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire_s) begin
            main_d  = new_s;
            state_d = ST_ONE;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            main_d = new_s;
          end else if (in_fire_s) begin
            skid_d  = new_s;
            state_d = ST_FULL;
          end else if (out_fire_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          if (out_fire_s) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    if (in_fire_s && new_s.err && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_valid = (state_q != ST_EMPTY);
  assign out_imm   = main_q.imm;
  assign out_tag   = main_q.tag;
  assign out_err   = main_q.err;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench: one XLEN=32/CNT_W=8 instance and one XLEN=64/CNT_W=2 instance
// share the same stimulus; each scenario task checks its own expected values.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_tag;
  logic [2:0]  in_imm_sel;

  logic        a_in_ready, a_out_valid, a_out_err;
  logic [31:0] a_out_imm, a_out_tag;
  logic [7:0]  a_err_cnt;
  logic        b_in_ready, b_out_valid, b_out_err;
  logic [63:0] b_out_imm;
  logic [31:0] b_out_tag;
  logic [1:0]  b_err_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .TAG_W(32), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_imm_sel(in_imm_sel), .in_tag(in_tag),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_out_imm),
    .out_tag(a_out_tag), .out_err(a_out_err), .err_cnt(a_err_cnt)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(32), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_imm_sel(in_imm_sel), .in_tag(in_tag),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_imm(b_out_imm),
    .out_tag(b_out_tag), .out_err(b_out_err), .err_cnt(b_err_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [2:0] sel, input logic [31:0] tag);
    in_valid   = 1'b1;
    in_instr   = instr;
    in_imm_sel = sel;
    in_tag     = tag;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({a_in_ready, b_in_ready} !== 2'b00) begin
      n_err++; $display("FAIL reset_in_ready got %b want 00", {a_in_ready, b_in_ready});
    end
    n_vec++;
    if ({a_out_valid, a_out_imm, a_out_tag, a_out_err, a_err_cnt} !== 74'd0) begin
      n_err++; $display("FAIL reset_outs_a got v=%b imm=%h tag=%h err=%b cnt=%0d want zeros",
                        a_out_valid, a_out_imm, a_out_tag, a_out_err, a_err_cnt);
    end
    n_vec++;
    if ({b_out_valid, b_out_imm, b_out_tag, b_out_err, b_err_cnt} !== 100'd0) begin
      n_err++; $display("FAIL reset_outs_b got v=%b imm=%h tag=%h err=%b cnt=%0d want zeros",
                        b_out_valid, b_out_imm, b_out_tag, b_out_err, b_err_cnt);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if ({a_in_ready, b_in_ready} !== 2'b11) begin
      n_err++; $display("FAIL post_reset_in_ready got %b want 11", {a_in_ready, b_in_ready});
    end
  endtask

  task automatic test_formats();
    out_ready = 1'b1;
    offer(32'hFFF00093, 3'b000, 32'h100);
    tick();
    n_vec++;
    if ({a_out_valid, a_out_imm, a_out_tag, a_out_err} !== {1'b1, 32'hFFFFFFFF, 32'h100, 1'b0}) begin
      n_err++; $display("FAIL itype_a got v=%b imm=%h tag=%h err=%b want 1/ffffffff/100/0",
                        a_out_valid, a_out_imm, a_out_tag, a_out_err);
    end
    n_vec++;
    if (b_out_imm !== 64'hFFFFFFFFFFFFFFFF) begin
      n_err++; $display("FAIL itype_b got %h want ffffffffffffffff", b_out_imm);
    end
    offer(32'hFE000C00, 3'b001, 32'h101);
    tick();
    n_vec++;
    if ({a_out_imm, a_out_tag} !== {32'hFFFFFFF8, 32'h101}) begin
      n_err++; $display("FAIL stype_a got imm=%h tag=%h want fffffff8/101", a_out_imm, a_out_tag);
    end
    offer(32'hFE000EE3, 3'b010, 32'h102);
    tick();
    n_vec++;
    if (a_out_imm !== 32'hFFFFFFFC) begin
      n_err++; $display("FAIL btype_a got %h want fffffffc", a_out_imm);
    end
    offer(32'h800000B7, 3'b011, 32'h103);
    tick();
    n_vec++;
    if ({a_out_imm, b_out_imm} !== {32'h80000000, 64'hFFFFFFFF80000000}) begin
      n_err++; $display("FAIL utype got a=%h b=%h want 80000000/ffffffff80000000", a_out_imm, b_out_imm);
    end
    offer(32'h0030106F, 3'b100, 32'h104);
    tick();
    n_vec++;
    if ({a_out_imm, b_out_imm} !== {32'h00001802, 64'h0000000000001802}) begin
      n_err++; $display("FAIL jtype got a=%h b=%h want 1802", a_out_imm, b_out_imm);
    end
    offer(32'h0002D073, 3'b101, 32'h105);
    tick();
    n_vec++;
    if ({b_out_imm, b_out_tag, b_out_err} !== {64'h5, 32'h105, 1'b0}) begin
      n_err++; $display("FAIL ztype_b got imm=%h tag=%h err=%b want 5/105/0", b_out_imm, b_out_tag, b_out_err);
    end
    in_valid = 1'b0;
    tick();
    n_vec++;
    if ({a_out_valid, b_out_valid} !== 2'b00) begin
      n_err++; $display("FAIL drain_valid got %b want 00", {a_out_valid, b_out_valid});
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    offer(32'h00100093, 3'b000, 32'd1);
    tick();
    n_vec++;
    if ({a_in_ready, a_out_valid, a_out_tag} !== {1'b1, 1'b1, 32'd1}) begin
      n_err++; $display("FAIL bp_first got rdy=%b v=%b tag=%0d want 1/1/1", a_in_ready, a_out_valid, a_out_tag);
    end
    offer(32'h00200093, 3'b000, 32'd2);
    tick();
    n_vec++;
    if ({a_in_ready, b_in_ready, a_out_tag} !== {1'b0, 1'b0, 32'd1}) begin
      n_err++; $display("FAIL bp_full got rdy=%b%b tag=%0d want 00/1", a_in_ready, b_in_ready, a_out_tag);
    end
    offer(32'h00300093, 3'b000, 32'd3);
    tick();
    n_vec++;
    if ({a_in_ready, a_out_valid, a_out_tag, a_out_imm} !== {1'b0, 1'b1, 32'd1, 32'd1}) begin
      n_err++; $display("FAIL bp_hold got rdy=%b v=%b tag=%0d imm=%h want 0/1/1/1",
                        a_in_ready, a_out_valid, a_out_tag, a_out_imm);
    end
    out_ready = 1'b1;
    tick();
    n_vec++;
    if ({a_in_ready, a_out_tag, a_out_imm, b_out_tag} !== {1'b1, 32'd2, 32'd2, 32'd2}) begin
      n_err++; $display("FAIL bp_second got rdy=%b tag=%0d imm=%h want 1/2/2", a_in_ready, a_out_tag, a_out_imm);
    end
    tick();
    in_valid = 1'b0;
    n_vec++;
    if ({a_out_valid, a_out_tag, a_out_imm, b_out_tag} !== {1'b1, 32'd3, 32'd3, 32'd3}) begin
      n_err++; $display("FAIL bp_third got v=%b tag=%0d imm=%h want 1/3/3", a_out_valid, a_out_tag, a_out_imm);
    end
    tick();
    n_vec++;
    if (a_out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_empty got v=%b want 0", a_out_valid);
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      offer(32'hFFFFFFFF, 3'b110, 32'h200 + i);
      tick();
      n_vec++;
      if ({a_out_valid, a_out_imm, a_out_err, b_out_imm, b_out_err, a_out_tag} !==
          {1'b1, 32'd0, 1'b1, 64'd0, 1'b1, 32'h200 + i}) begin
        n_err++; $display("FAIL illegal_out[%0d] got v=%b a=%h/%b b=%h/%b tag=%h want 1/0/1/0/1",
                          i, a_out_valid, a_out_imm, a_out_err, b_out_imm, b_out_err, a_out_tag);
      end
      n_vec++;
      if ({a_err_cnt, b_err_cnt} !== {8'(i + 1), (i >= 2) ? 2'd3 : 2'(i + 1)}) begin
        n_err++; $display("FAIL illegal_cnt[%0d] got a=%0d b=%0d want a=%0d b=%0d",
                          i, a_err_cnt, b_err_cnt, i + 1, (i >= 2) ? 3 : i + 1);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush_reset();
    out_ready = 1'b0;
    offer(32'h00100093, 3'b000, 32'hA);
    tick();
    offer(32'h00200093, 3'b000, 32'hB);
    tick();
    n_vec++;
    if (a_in_ready !== 1'b0) begin
      n_err++; $display("FAIL flush_fill got rdy=%b want 0", a_in_ready);
    end
    offer(32'h00300093, 3'b110, 32'hC);
    flush = 1'b1;
    #1;
    n_vec++;
    if (a_in_ready !== 1'b0) begin
      n_err++; $display("FAIL flush_full_rdy got %b want 0", a_in_ready);
    end
    tick();
    n_vec++;
    if ({a_out_valid, b_out_valid, a_err_cnt, b_err_cnt, a_in_ready} !== {1'b0, 1'b0, 8'd5, 2'd3, 1'b1}) begin
      n_err++; $display("FAIL flush_full got v=%b%b cnt=%0d/%0d rdy=%b want 00/5/3/1",
                        a_out_valid, b_out_valid, a_err_cnt, b_err_cnt, a_in_ready);
    end
    offer(32'h00300093, 3'b110, 32'hD);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_vec++;
    if ({a_out_valid, a_err_cnt} !== {1'b0, 8'd5}) begin
      n_err++; $display("FAIL flush_one_cycle_offer got v=%b cnt=%0d want 0/5", a_out_valid, a_err_cnt);
    end
    tick();
    n_vec++;
    if (a_out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_no_accept got v=%b want 0", a_out_valid);
    end
    offer(32'h00100093, 3'b000, 32'hE);
    tick();
    offer(32'h00200093, 3'b000, 32'hF);
    tick();
    offer(32'hFFFFFFFF, 3'b110, 32'h10);
    rst = 1'b1;
    tick();
    n_vec++;
    if ({a_out_valid, a_out_imm, a_out_tag, a_out_err, a_err_cnt, a_in_ready} !== 75'd0) begin
      n_err++; $display("FAIL rst_full_a got v=%b imm=%h tag=%h err=%b cnt=%0d rdy=%b want zeros",
                        a_out_valid, a_out_imm, a_out_tag, a_out_err, a_err_cnt, a_in_ready);
    end
    n_vec++;
    if ({b_out_valid, b_out_imm, b_out_tag, b_out_err, b_err_cnt} !== 100'd0) begin
      n_err++; $display("FAIL rst_full_b got v=%b imm=%h cnt=%0d want zeros", b_out_valid, b_out_imm, b_err_cnt);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    n_vec++;
    if ({a_in_ready, b_in_ready} !== 2'b11) begin
      n_err++; $display("FAIL rst_release_rdy got %b want 11", {a_in_ready, b_in_ready});
    end
    tick();
    n_vec++;
    if ({a_out_valid, b_out_valid} !== 2'b00) begin
      n_err++; $display("FAIL rst_stays_empty got %b want 00", {a_out_valid, b_out_valid});
    end
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_instr   = 32'd0;
    in_imm_sel = 3'd0;
    in_tag     = 32'd0;
    test_reset();
    test_formats();
    test_back_to_back();
    test_illegal();
    test_flush_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Pipelined, parametrised immediate generator for the decode stage. It accepts a 32-bit instruction word plus an immediate-format select over a valid/ready handshake and extracts and sign-extends the immediate to XLEN bits. The result is registered behind a 2-entry skid buffer and carries a tag (PC or ROB id) through unchanged. It adds a CSR zero-extended immediate, illegal-select flagging, a saturating error counter and pipeline flush.

## Interface
- XLEN, 32: output immediate width; legal values 32 or 64.
- TAG_W, 32: width of the pass-through tag.
- CNT_W, 8: width of the saturating illegal-select counter.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  drop all buffered entries.
- in_valid  in  1  input transaction offered.
- in_ready  out  1  block can accept.
- in_instr  in  32  instruction word; only bits [31:7] are used.
- in_imm_sel  in  3  format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z (CSR zimm), 110/111 illegal.
- in_tag  in  TAG_W  passed through unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_imm  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag of the result.
- out_err  out  1  result came from an illegal select.
- err_cnt  out  CNT_W  count of accepted illegal selects, saturating.

## Operation
- Extraction is combinational at the input; sext() replicates instr[31] up to XLEN.
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: sext({instr[31:12], 12'b0}); for XLEN=64, sign-extended from bit 31.
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - Z: zero-extend instr[19:15].
  - Illegal (110/111): imm = 0, err = 1.
- Input fire = in_valid & in_ready & !flush. Output fire = out_valid & out_ready.
- Storage is a main register (drives the outputs) and a skid register. The buffer state is one of:
  - EMPTY: input fire -> ONE.
  - ONE: input fire with output fire -> ONE, main reloaded. Input fire without output fire -> FULL, new entry goes to skid. Output fire only -> EMPTY.
  - FULL: output fire -> ONE, skid moves to main. No input can be accepted.
- in_ready = !skid_valid & !rst. It is driven from state only, with no combinational path from out_ready.
- Ordering is strict FIFO; no entry is dropped or duplicated except by flush or rst.
- err_cnt increments by 1 on each input fire with an illegal select and holds at 2^CNT_W-1. flush does not clear it; only rst does.
- flush: the next state is EMPTY. An input offered in the flush cycle is not accepted and not counted.

## Timing
- Latency: input fire at edge N gives out_valid=1 after edge N, with the result on out_imm/out_tag/out_err.
- Throughput: 1 transaction per cycle while out_ready=1.
- Backpressure: with out_ready=0, two transactions are accepted, then in_ready=0 after the second accepting edge. in_ready returns to 1 the cycle after the first output fire.
- Outputs are stable while out_valid=1 and out_ready=0.
- Reset values after an rst edge: out_valid=0, out_imm=0, out_tag=0, out_err=0, err_cnt=0, skid empty. in_ready=0 while rst=1 and 1 in the first cycle after.
- rst or flush in state FULL: both entries are discarded at that edge and out_valid=0 the next cycle.
- rst and flush together: rst takes priority.

## Test plan
- I-type, XLEN=32: in_instr=0xFFF00093, sel=000, tag=0x100 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_tag=0x100, out_err=0.
- B-type, XLEN=32: in_instr=0xFE000EE3, sel=010 -> out_imm=0xFFFFFFFC.
- U-type and Z, XLEN=64: in_instr=0x800000B7, sel=011 -> out_imm=0xFFFFFFFF80000000. Then in_instr=0x0002D073, sel=101 -> out_imm=0x5.
- Backpressure: out_ready=0, offer tags 1,2,3 back-to-back -> tags 1 and 2 accepted, in_ready=0, tag 3 held. Raise out_ready -> outputs 1,2,3 in order on consecutive cycles.
- Illegal select, CNT_W=2: five accepted sel=110 transactions -> each gives out_imm=0 and out_err=1; err_cnt reads 1,2,3,3,3.
- Flush/reset mid-operation: fill to FULL, pulse flush together with an offered input -> out_valid=0 next cycle, input not accepted, err_cnt unchanged. Repeat with rst -> all outputs at reset values.
